// File: rtl/zkr_seed_ctrl_pkg.sv
// Shared types and constants for the Zkr seed sequencer.
package zkr_seed_ctrl_pkg;

    // OPST encoding as seen by software in seed[31:30]
    typedef enum logic [1:0] {
        BIST = 2'b00,
        WAIT = 2'b01,
        ES16 = 2'b10,
        DEAD = 2'b11
    } opst_t;

    localparam logic [11:0] SEED_CSR_ADR = 12'h015;

    localparam int ZKR_BIST_BITS  = 64;
    localparam int ZKR_RCT_CUTOFF = 32;
    localparam int ZKR_APT_WINDOW = 64;
    localparam int ZKR_APT_LO     = 16;
    localparam int ZKR_APT_HI     = 48;
    localparam int ZKR_WORD_BITS  = 16;

    // Entropy is only ever exposed while OPST is ES16
    function automatic logic [31:0] seed_word(input opst_t st, input logic [15:0] data);
        if (st == ES16) begin
            return {st, 14'b0, data};
        end
        return {st, 30'b0};
    endfunction

endpackage

// File: rtl/zkr_seed_ctrl_health.sv
// Continuous health tests on the raw entropy stream: repetition count (RCT)
// and adaptive proportion (APT). The fault output is a single-cycle pulse,
// combinational from the bit being tested, so the sequencer can act on the
// same clock edge that samples the offending bit.
module zkr_health_test
    import zkr_seed_ctrl_pkg::*;
#(
    parameter int RCT_CUTOFF = ZKR_RCT_CUTOFF,
    parameter int APT_WINDOW = ZKR_APT_WINDOW,
    parameter int APT_LO     = ZKR_APT_LO,
    parameter int APT_HI     = ZKR_APT_HI
) (
    input  logic clk,
    input  logic reset,
    input  logic i_bit,
    input  logic i_valid,
    input  logic i_hold,
    output logic o_fault
);

    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
    localparam int WIN_W = $clog2(APT_WINDOW + 1);

    logic [RUN_W-1:0] r_run_cnt;
    logic             r_last_bit;
    logic [WIN_W-1:0] r_win_cnt;
    logic [WIN_W-1:0] r_ones_cnt;

    logic [RUN_W-1:0] w_run_next;
    logic [WIN_W-1:0] w_ones_next;
    logic             w_active;
    logic             w_win_end;
    logic             w_rct_fault;
    logic             w_apt_fault;

    // Next-count computation; both counters saturate instead of wrapping
    always_comb begin
        w_active = i_valid && !i_hold;

        // A zero run count means no bit has been seen since reset
        if ((r_run_cnt == '0) || (i_bit != r_last_bit)) begin
            w_run_next = RUN_W'(1);
        end else if (r_run_cnt == RUN_W'(RCT_CUTOFF)) begin
            w_run_next = r_run_cnt;
        end else begin
            w_run_next = r_run_cnt + RUN_W'(1);
        end

        if (r_ones_cnt == WIN_W'(APT_WINDOW)) begin
            w_ones_next = r_ones_cnt;
        end else begin
            w_ones_next = r_ones_cnt + WIN_W'(i_bit);
        end

        w_win_end   = (r_win_cnt == WIN_W'(APT_WINDOW - 1));
        // Only the transition onto the cutoff flags, keeping the fault a pulse
        w_rct_fault = (w_run_next == RUN_W'(RCT_CUTOFF)) && (r_run_cnt != RUN_W'(RCT_CUTOFF));
        w_apt_fault = w_win_end &&
                      ((w_ones_next < WIN_W'(APT_LO)) || (w_ones_next > WIN_W'(APT_HI)));
        o_fault     = w_active && (w_rct_fault || w_apt_fault);
    end

    // Counter state advances only on tested bits; hold freezes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_cnt  <= '0;
            r_last_bit <= 1'b0;
            r_win_cnt  <= '0;
            r_ones_cnt <= '0;
        end else if (w_active) begin
            r_run_cnt  <= w_run_next;
            r_last_bit <= i_bit;
            if (w_win_end) begin
                r_win_cnt  <= '0;
                r_ones_cnt <= '0;
            end else begin
                r_win_cnt  <= r_win_cnt + WIN_W'(1);
                r_ones_cnt <= w_ones_next;
            end
        end
    end

endmodule

// File: rtl/zkr_seed_ctrl.sv
// Zkr seed CSR sequencer: entropy-source enable, power-on self test,
// 16-bit entropy packing and seed-CSR read service with OPST status.
//
//  state | meaning
//  BIST  | power-on self test; 64 healthy bits required, none issued
//  WAIT  | gathering 16 fresh bits into the shift register
//  ES16  | seed word ready; source disabled until software reads it
//  DEAD  | health test failed; sticky until reset
module zkr_seed_ctrl
    import zkr_seed_ctrl_pkg::*;
#(
    parameter int BIST_BITS  = ZKR_BIST_BITS,
    parameter int RCT_CUTOFF = ZKR_RCT_CUTOFF,
    parameter int APT_WINDOW = ZKR_APT_WINDOW,
    parameter int APT_LO     = ZKR_APT_LO,
    parameter int APT_HI     = ZKR_APT_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EsBitI,
    input  logic        EsValidI,
    output logic        EsEnableO,
    input  logic        SeedReadM,
    output logic [31:0] SeedReadValM,
    output logic        HealthFaultO
);

    localparam int BIST_CNT_W = $clog2(BIST_BITS + 1);
    localparam int BIT_CNT_W  = $clog2(ZKR_WORD_BITS + 1);

    opst_t                 r_state;
    logic [15:0]           r_shreg;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BIST_CNT_W-1:0] r_bist_cnt;
    logic                  r_es_enable;
    logic                  r_health_fault;

    logic                  w_hold;
    logic                  w_sample;
    logic                  w_fault;
    logic [15:0]           w_shreg_next;
    logic [BIT_CNT_W-1:0]  w_bit_cnt_next;

    // Sampling and health testing are live only while collecting bits
    always_comb begin
        w_hold         = !((r_state == BIST) || (r_state == WAIT));
        w_sample       = EsValidI && !w_hold;
        w_shreg_next   = {r_shreg[14:0], EsBitI};
        w_bit_cnt_next = (r_bit_cnt == BIT_CNT_W'(ZKR_WORD_BITS)) ? r_bit_cnt
                                                                  : r_bit_cnt + BIT_CNT_W'(1);
    end

    zkr_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_LO     (APT_LO),
        .APT_HI     (APT_HI)
    ) u_health (
        .clk     (clk),
        .reset   (reset),
        .i_bit   (EsBitI),
        .i_valid (EsValidI),
        .i_hold  (w_hold),
        .o_fault (w_fault)
    );

    // Sequencer FSM with registered enable and fault outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= BIST;
            r_shreg        <= '0;
            r_bit_cnt      <= '0;
            r_bist_cnt     <= '0;
            r_es_enable    <= 1'b1;
            r_health_fault <= 1'b0;
        end else begin
            case (r_state)
                BIST: begin
                    if (w_sample) begin
                        if (w_fault) begin
                            r_state        <= DEAD;
                            r_es_enable    <= 1'b0;
                            r_health_fault <= 1'b1;
                        end else if (r_bist_cnt == BIST_CNT_W'(BIST_BITS - 1)) begin
                            // Self-test bits are discarded, never issued
                            r_state   <= WAIT;
                            r_shreg   <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_shreg    <= w_shreg_next;
                            r_bit_cnt  <= w_bit_cnt_next;
                            r_bist_cnt <= r_bist_cnt + BIST_CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    // Re-enable lags entry into WAIT by one cycle
                    r_es_enable <= 1'b1;
                    if (w_sample) begin
                        if (w_fault) begin
                            r_state        <= DEAD;
                            r_es_enable    <= 1'b0;
                            r_health_fault <= 1'b1;
                        end else begin
                            r_shreg   <= w_shreg_next;
                            r_bit_cnt <= w_bit_cnt_next;
                            if (r_bit_cnt == BIT_CNT_W'(ZKR_WORD_BITS - 1)) begin
                                r_state     <= ES16;
                                r_es_enable <= 1'b0;
                            end
                        end
                    end
                end
                ES16: begin
                    r_es_enable <= 1'b0;
                    // Wipe consumed entropy so it can never be read twice
                    if (SeedReadM) begin
                        r_state   <= WAIT;
                        r_shreg   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                DEAD: begin
                    r_es_enable    <= 1'b0;
                    r_health_fault <= 1'b1;
                end
            endcase
        end
    end

    // Read data depends on state only, so a read sees it in its own cycle
    always_comb begin
        SeedReadValM = seed_word(r_state, r_shreg);
        EsEnableO    = r_es_enable;
        HealthFaultO = r_health_fault;
    end

endmodule
